// File: rtl/wts_timer_counter_pkg.sv
// Shared definitions for the WTS interval timer block: default width and channel FSM states.
package wts_timer_counter_pkg;

    localparam int unsigned CNT_W_DEFAULT = 12;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/wts_timer_counter_channel.sv
// One programmable down-counting interval timer: reload on start/load/expiry,
// combinational expiry strobe for cascading, registered one-clk trigger.
module wts_timer_channel
    import wts_timer_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] period,
    input  logic             run,
    input  logic             load,
    input  logic             count_en,
    output logic [CNT_W-1:0] count,
    output logic             expire,
    output logic             trigger
);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             trigger_q, trigger_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_STOP;
            count_q   <= '0;
            trigger_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            trigger_q <= trigger_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        unique case (state_q)
            ST_STOP: begin
                if (run || load) begin
                    count_d = period;
                end
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_STOP;
                    if (load) begin
                        count_d = period;
                    end
                end else if (load) begin
                    // load beats a coincident count event: no decrement, no expiry
                    count_d = period;
                end else if (count_en) begin
                    if (count_q == CNT_W'(1)) begin
                        expire  = 1'b1;
                        count_d = period;
                    end else begin
                        // a period of 0 reaches here as 0 and wraps to all-ones: 2^CNT_W interval
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_STOP;
        endcase
        trigger_d = expire;
    end

    assign count   = count_q;
    assign trigger = trigger_q;

endmodule

// File: rtl/wts_timer_counter.sv
// Two WTS interval timers; timer 2 optionally counts timer 1 expiries instead of base ticks.
module wts_timer_counter
    import wts_timer_counter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_base,
    input  logic [CNT_W-1:0] reg_timer1_period,
    input  logic             reg_timer1_run,
    input  logic             reg_timer1_load,
    input  logic [CNT_W-1:0] reg_timer2_period,
    input  logic             reg_timer2_run,
    input  logic             reg_timer2_load,
    input  logic             reg_timer2_cascade,
    output logic             timer1_trigger,
    output logic             timer2_trigger,
    output logic [CNT_W-1:0] timer1_count,
    output logic [CNT_W-1:0] timer2_count
);

    logic ch1_expire;
    logic ch2_expire;
    logic ch2_count_en;

    // Same-clk expiry strobe so a cascaded timer 2 decrements on the expiring edge itself
    assign ch2_count_en = reg_timer2_cascade ? ch1_expire : tick_base;

    wts_timer_channel #(.CNT_W(CNT_W)) u_ch1 (
        .clk      (clk),
        .rst      (reset),
        .period   (reg_timer1_period),
        .run      (reg_timer1_run),
        .load     (reg_timer1_load),
        .count_en (tick_base),
        .count    (timer1_count),
        .expire   (ch1_expire),
        .trigger  (timer1_trigger)
    );

    wts_timer_channel #(.CNT_W(CNT_W)) u_ch2 (
        .clk      (clk),
        .rst      (reset),
        .period   (reg_timer2_period),
        .run      (reg_timer2_run),
        .load     (reg_timer2_load),
        .count_en (ch2_count_en),
        .count    (timer2_count),
        .expire   (ch2_expire),
        .trigger  (timer2_trigger)
    );

endmodule
